mdio_master: RTL and testbench

//  Parametrised IEEE 802.3 clause-22 MDIO management master for the ethernet PHY.

---
 rtl/mdio_master.sv | 151 +++++++++++++++
 tb/tb_mdio_master.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mdio_master.sv
// rtl/mdio_master.sv - clause-22 MDIO management master, one read/write frame per request
module mdio_master #(
  parameter int MDC_HALF     = 10,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        we,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_z,
  input  logic        mdio_in
);

  localparam int PW = $clog2(2 * MDC_HALF);
  localparam int BW = $clog2((PREAMBLE_LEN > 16 ? PREAMBLE_LEN : 16) + 1);
  localparam logic [PW-1:0] PH_RISE = PW'(MDC_HALF - 1);
  localparam logic [PW-1:0] PH_LAST = PW'(2 * MDC_HALF - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_HDR  = 3'd2;
  localparam logic [2:0] S_TA   = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_END  = 3'd5;

  logic [2:0]    state;
  logic [PW-1:0] ph;
  logic [BW-1:0] bcnt;
  logic [31:0]   tx;
  logic [15:0]   rx;
  logic          wr_q;
  logic [31:0]   hdr;
  logic          last;

  // Everything after the preamble is serialised from one register; read frames
  // pad TA/DATA with ones since the pin is released there anyway.
  assign hdr  = {2'b01, (we ? 2'b01 : 2'b10), phy_addr, reg_addr,
                 (we ? {2'b10, wdata} : 18'h3FFFF)};
  assign last = (bcnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      ph       <= '0;
      bcnt     <= '0;
      tx       <= '1;
      rx       <= '0;
      wr_q     <= 1'b0;
      rdata    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
      mdc      <= 1'b0;
      mdio_out <= 1'b1;
      mdio_z   <= 1'b1;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy    <= 1'b1;
          ack_err <= 1'b0;
          wr_q    <= we;
          ph      <= '0;
          mdc     <= 1'b0;
          mdio_z  <= 1'b0;
          if (PREAMBLE_LEN != 0) begin
            state    <= S_PRE;
            bcnt     <= BW'(PREAMBLE_LEN - 1);
            mdio_out <= 1'b1;
            tx       <= hdr;
          end else begin
            state    <= S_HDR;
            bcnt     <= BW'(13);
            mdio_out <= hdr[31];
            tx       <= {hdr[30:0], 1'b1};
          end
        end
      end else begin
        ph <= ph + 1'b1;
        // mdio_in is captured on the edge where mdc rises
        if (ph == PH_RISE) begin
          mdc <= 1'b1;
          if (!wr_q && state == S_TA && last) ack_err <= mdio_in;
          if (!wr_q && state == S_DATA) rx <= {rx[14:0], mdio_in};
        end
        if (ph == PH_LAST) begin
          ph       <= '0;
          mdc      <= 1'b0;
          bcnt     <= bcnt - 1'b1;
          mdio_out <= tx[31];
          tx       <= {tx[30:0], 1'b1};
          case (state)
            S_PRE: begin
              if (last) begin
                state <= S_HDR;
                bcnt  <= BW'(13);
              end else begin
                mdio_out <= 1'b1;
                tx       <= tx;
              end
            end
            S_HDR: begin
              if (last) begin
                state  <= S_TA;
                bcnt   <= BW'(1);
                mdio_z <= ~wr_q;
              end
            end
            S_TA: begin
              if (last) begin
                state <= S_DATA;
                bcnt  <= BW'(15);
              end
            end
            S_DATA: begin
              if (last) begin
                state    <= S_END;
                bcnt     <= '0;
                mdio_z   <= 1'b1;
                mdio_out <= 1'b1;
              end
            end
            S_END: begin
              state    <= S_IDLE;
              bcnt     <= '0;
              busy     <= 1'b0;
              done     <= 1'b1;
              mdio_z   <= 1'b1;
              mdio_out <= 1'b1;
              if (!wr_q) rdata <= rx;
            end
            default: begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// tb/tb_mdio_master.sv - directed bench for mdio_master (default and short-frame instances)
module tb_mdio_master;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        start, we, mdio_in;
  logic [4:0]  phy_addr, reg_addr;
  logic [15:0] wdata, rdata;
  logic        busy, done, ack_err, mdc, mdio_out, mdio_z;

  logic        start2, mdio_in2;
  logic [15:0] rdata2;
  logic        busy2, done2, ack_err2, mdc2, mdio_out2, mdio_z2;

  mdio_master dut (
    .clk(clk), .reset(reset), .start(start), .we(we), .phy_addr(phy_addr),
    .reg_addr(reg_addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .ack_err(ack_err), .mdc(mdc), .mdio_out(mdio_out), .mdio_z(mdio_z), .mdio_in(mdio_in)
  );

  mdio_master #(.MDC_HALF(2), .PREAMBLE_LEN(0)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .we(we), .phy_addr(phy_addr),
    .reg_addr(reg_addr), .wdata(wdata), .rdata(rdata2), .busy(busy2), .done(done2),
    .ack_err(ack_err2), .mdc(mdc2), .mdio_out(mdio_out2), .mdio_z(mdio_z2), .mdio_in(mdio_in2)
  );

  int total = 0;
  int bad = 0;
  int done_cyc, z_err;
  logic [63:0] bits;
  logic ack_at1, busy_at1, z_at1;

  localparam logic [63:0] EXP1 = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h3100};
  localparam logic [45:0] EXP2 = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'h1F, 5'h01};
  localparam logic [31:0] EXP5 = {2'b01, 2'b01, 5'd3, 5'd4, 2'b10, 16'hA5C3};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one frame on the default instance; the PHY model answers reads with
  // TA2=0 and resp, or leaves the line pulled high when phy_ok=0.
  task automatic frame(input logic w, input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] wd, input logic phy_ok, input logic [15:0] resp,
                       input logic hold, input int repulse, input int abort_at);
    int c, k, nr;
    logic zexp, pm;
    we = w; phy_addr = pa; reg_addr = ra; wdata = wd;
    start = 1'b1; mdio_in = 1'b1;
    bits = '0; z_err = 0; done_cyc = -1; nr = 0; pm = mdc;
    tick();
    c = 1;
    ack_at1 = ack_err; busy_at1 = busy; z_at1 = mdio_z;
    while (c <= 1400) begin
      start = hold || (c == repulse);
      k = (c - 1) / 20;
      if (!phy_ok || k < 47 || k > 63) mdio_in = 1'b1;
      else if (k == 47) mdio_in = 1'b0;
      else mdio_in = resp[63 - k];
      if (done) begin
        done_cyc = c;
        break;
      end
      zexp = w ? (k >= 64) : (k >= 46);
      if (mdio_z !== zexp) z_err++;
      if (mdc && !pm && nr < 64) begin
        bits = {bits[62:0], mdio_out};
        nr++;
      end
      pm = mdc;
      if (c == abort_at) break;
      tick();
      c++;
    end
    if (!hold) start = 1'b0;
  endtask

  initial begin
    int c, r0, r1, nr, busy_hits;
    logic pm;
    logic [31:0] bits2;
    start = 0; start2 = 0; we = 0; phy_addr = 0; reg_addr = 0; wdata = 0;
    mdio_in = 1; mdio_in2 = 1;
    tick(); tick();
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_err", ack_err, 0);
    chk("rst_mdc", mdc, 0);
    chk("rst_mdio_out", mdio_out, 1);
    chk("rst_mdio_z", mdio_z, 1);
    reset = 0;
    tick();

    frame(1, 5'd1, 5'd0, 16'h3100, 1, 16'h0, 0, -1, -1);
    chk("wr_done_cyc", done_cyc, 1301);
    chk("wr_bits", bits, EXP1);
    chk("wr_z", z_err, 0);
    chk("wr_rdata_kept", rdata, 0);
    chk("wr_busy_at_done", busy, 0);
    chk("wr_mdc_idle", mdc, 0);
    chk("wr_z_idle", mdio_z, 1);
    tick();
    chk("done_one_cycle", done, 0);

    frame(0, 5'h1F, 5'd1, 16'h0, 1, 16'h786D, 0, -1, -1);
    chk("rd_done_cyc", done_cyc, 1301);
    chk("rd_rdata", rdata, 16'h786D);
    chk("rd_ack_err", ack_err, 0);
    chk("rd_z", z_err, 0);
    chk("rd_hdr_bits", bits[63:18], EXP2);

    frame(0, 5'd2, 5'd3, 16'h0, 0, 16'h0, 0, -1, -1);
    chk("nophy_rdata", rdata, 16'hFFFF);
    chk("nophy_ack_err", ack_err, 1);
    frame(0, 5'h1F, 5'd1, 16'h0, 1, 16'h1234, 0, -1, -1);
    chk("ack_clr_at_accept", ack_at1, 0);
    chk("good_rdata", rdata, 16'h1234);
    chk("good_ack_err", ack_err, 0);

    frame(1, 5'd1, 5'd0, 16'h3100, 1, 16'h0, 0, 500, -1);
    chk("repulse_done_cyc", done_cyc, 1301);
    busy_hits = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy) busy_hits++;
    end
    chk("repulse_no_2nd", busy_hits, 0);

    frame(1, 5'd4, 5'd5, 16'hBEEF, 1, 16'h0, 1, -1, -1);
    chk("hold1_done_cyc", done_cyc, 1301);
    frame(1, 5'd4, 5'd5, 16'hBEEF, 1, 16'h0, 0, -1, -1);
    chk("hold2_busy_c1", busy_at1, 1);
    chk("hold2_z_c1", z_at1, 0);
    chk("hold2_done_cyc", done_cyc, 1301);
    chk("hold2_bits", bits, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd4, 5'd5, 2'b10, 16'hBEEF});

    frame(1, 5'd1, 5'd0, 16'h3100, 1, 16'h0, 0, -1, 1115);
    chk("pre_rst_mdc", mdc, 1);
    reset = 1;
    #1;
    chk("arst_mdc", mdc, 0);
    chk("arst_z", mdio_z, 1);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_out", mdio_out, 1);
    tick();
    reset = 0;
    tick();
    frame(1, 5'd1, 5'd0, 16'h3100, 1, 16'h0, 0, -1, -1);
    chk("after_rst_done_cyc", done_cyc, 1301);
    chk("after_rst_bits", bits, EXP1);
    chk("after_rst_z", z_err, 0);

    we = 1; phy_addr = 5'd3; reg_addr = 5'd4; wdata = 16'hA5C3;
    start2 = 1;
    tick();
    start2 = 0;
    chk("s_first_bit", mdio_out2, 0);
    chk("s_first_z", mdio_z2, 0);
    c = 1; r0 = -1; r1 = -1; nr = 0; pm = mdc2; bits2 = '0; done_cyc = -1;
    while (c <= 300) begin
      if (done2) begin
        done_cyc = c;
        break;
      end
      if (mdc2 && !pm) begin
        if (nr < 32) bits2 = {bits2[30:0], mdio_out2};
        if (nr == 0) r0 = c;
        if (nr == 1) r1 = c;
        nr++;
      end
      pm = mdc2;
      tick();
      c++;
    end
    chk("s_done_cyc", done_cyc, 133);
    chk("s_bits", bits2, EXP5);
    chk("s_mdc_period", r1 - r0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
